// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that picks one of eight requesters and steers that
// requester's data bit onto y. A grant lasts until the owner drops its
// request or MAX_BURST transfers complete. Every release is followed by an
// IDLE bubble, so the next arbitration always sees a refreshed pointer.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; arbitrate among req starting the search at ptr
// GRANT | requester sel owns the output; count accepted transfers
module mux_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] d,
  input  logic       out_ready,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       out_valid,
  output logic       y
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Last accepted transfer of a burst happens while bcnt holds this value.
  localparam logic [3:0] BCNT_LAST = 4'(MAX_BURST - 1);

  state_t     state;
  logic [2:0] ptr;
  logic [3:0] bcnt;

  logic [7:0] req_rot;
  logic [2:0] win_off;
  logic [2:0] winner;
  logic       owner_req;
  logic       xfer;
  logic       burst_done;

  // Rotate req so the search origin (ptr) lands on bit 0, then take the
  // lowest set bit; adding ptr back wraps naturally in 3 bits.
  always_comb begin
    req_rot = 8'({req, req} >> ptr);
    win_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_off = 3'(i);
      end
    end
    winner = ptr + win_off;
  end

  // Output-side handshake: valid only while the owner keeps requesting.
  always_comb begin
    owner_req  = req[sel];
    out_valid  = (state == GRANT) && owner_req;
    y          = out_valid && d[sel];
    xfer       = out_valid && out_ready;
    burst_done = xfer && (bcnt == BCNT_LAST);
  end

  // Arbitration FSM; gnt and sel are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 3'd0;
      bcnt  <= 4'd0;
      sel   <= 3'd0;
      gnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= GRANT;
            sel   <= winner;
            gnt   <= 8'(8'b1 << winner);
            bcnt  <= 4'd0;
          end
        end
        GRANT: begin
          // A dropped request takes priority; it yields the same single
          // release as a completed burst, so both share one path.
          if (!owner_req || burst_done) begin
            state <= IDLE;
            ptr   <= sel + 3'd1;
            gnt   <= 8'd0;
            bcnt  <= 4'd0;
          end else if (xfer) begin
            bcnt <= bcnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 8'd0;
          bcnt  <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 4, maximum transfers per grant before forced release (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  8  request from requester i on bit i.
REQ-005 d  input  8  data bit from requester i on bit i.
REQ-006 out_ready  input  1  downstream accepts y this cycle.
REQ-007 gnt  output  8  one-hot grant, registered.
REQ-008 sel  output  3  registered index of the granted requester; drives the 8:1 select.
REQ-009 out_valid  output  1  y is valid this cycle.
REQ-010 y  output  1  selected data bit.

Function
REQ-011 The FSM SHALL have two states: IDLE and GRANT.
REQ-012 The block SHALL hold a 3-bit round-robin pointer ptr and a 4-bit burst counter bcnt.
REQ-013 In IDLE with req != 0, the winner SHALL be the first set req bit found searching ptr, ptr+1, ... mod 8, wrapping 7 to 0.
REQ-014 On that edge the FSM SHALL enter GRANT, with sel = winner, gnt = 1<<winner and bcnt = 0.
REQ-015 In IDLE with req == 0, all outputs SHALL hold their IDLE values: gnt=0, out_valid=0, y=0; sel and ptr unchanged.
REQ-016 Grant latency SHALL be exactly one cycle: req sampled in IDLE at edge k gives gnt and out_valid at edge k.
REQ-017 out_valid SHALL equal (state==GRANT) && req[sel], combinationally.
REQ-018 y SHALL equal d[sel] when out_valid=1 and 0 otherwise, combinationally from sel and d.
REQ-019 A transfer SHALL occur on a cycle with out_valid && out_ready; on that cycle bcnt SHALL increment.
REQ-020 Release: in GRANT, the FSM SHALL return to IDLE on the next edge when either condition holds:
  - (a) req[sel]=0; or
  - (b) a transfer occurs with bcnt == MAX_BURST-1.
REQ-021 On release, ptr SHALL become (sel+1) mod 8, gnt SHALL become 0 and bcnt SHALL become 0.
REQ-022 Every release SHALL be followed by at least one IDLE cycle (one-cycle bubble); no back-to-back grant.
REQ-023 While in GRANT with no release condition, sel, gnt and ptr SHALL be stable, including through out_ready=0 stalls of any length.
REQ-024 Changes on req bits other than req[sel] during GRANT SHALL have no effect until the next IDLE cycle.
REQ-025 Boundary: if req[sel] drops on the same cycle that bcnt reaches its limit, rule (a) applies, with the same single release.
REQ-026 Boundary: with MAX_BURST=1, every transfer SHALL release.
REQ-027 Boundary: a sole active requester SHALL be re-granted after each bubble, including when the wrapped ptr search returns to it.
REQ-028 gnt SHALL never have more than one bit set; gnt SHALL be nonzero only in GRANT.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately force the following, independent of clk, mid-burst included:
  - state=IDLE, ptr=0, bcnt=0, sel=0, gnt=0;
  - out_valid=0, y=0.
REQ-030 After rst_n rises, the first arbitration SHALL search from requester 0.

Verification
REQ-031 Reset, then req=8'b1000_0001, out_ready=1, MAX_BURST=4 -> gnt=8'h01, 4 transfers, bubble, gnt=8'h80, 4 transfers, bubble, gnt=8'h01.
REQ-032 ptr=0, req=8'h10, d=8'h10, out_ready=1 -> sel=4, y=1 on each out_valid cycle; with d=8'h00, y=0.
REQ-033 In GRANT for requester 2, hold out_ready=0 for 10 cycles -> out_valid=1, sel=2 stable, bcnt unchanged, no release.
REQ-034 Granted requester 5 drops req after 2 transfers -> out_valid=0 that cycle, IDLE next edge, ptr=6; pending req=8'h08 is granted after a wrapped search (6,7,0,1,2,3).
REQ-035 Assert rst_n=0 mid-burst (sel=6, bcnt=2) -> outputs zero asynchronously; after release with req=8'hC0, first grant is gnt=8'h40.
REQ-036 Random req/out_ready for 10,000 cycles -> gnt is always one-hot or zero, no requester waits more than 8 grants, and y==d[sel] whenever out_valid=1.
